// File: rtl/i2c_cmd_arbiter_if.sv
// Request/completion handshake plus the I2C_Controller GO/END bus, shared by
// the requesters, the arbiter and the slow-clocked controller.
interface i2c_cmd_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [24*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  done_valid;
  logic [1:0]            done_id;
  logic                  done_nack;
  logic                  done_timeout;
  logic                  busy;
  logic [23:0]           i2c_data;
  logic                  i2c_go;
  logic                  i2c_end;
  logic                  i2c_ack;

  // slave is the arbiter; master is everything around it
  modport slave (
    input  req_valid, req_data, i2c_end, i2c_ack,
    output req_ready, done_valid, done_id, done_nack, done_timeout, busy, i2c_data, i2c_go
  );

  modport master (
    output req_valid, req_data, i2c_end, i2c_ack,
    input  req_ready, done_valid, done_id, done_nack, done_timeout, busy, i2c_data, i2c_go
  );
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one I2C_Controller between NUM_REQ requesters,
// with NACK retry and a per-phase timeout on the GO/END handshake.
module i2c_cmd_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT_CYC = 2000000
) (
  input logic              CLOCK_50,
  input logic              iRST_N,
  i2c_cmd_arbiter_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, ARB, ISSUE, WAIT_END, WAIT_REL, CHECK, DONE} state_t;
  state_t state, state_n;

  logic               end_meta, end_s, ack_meta, ack_s;
  logic [1:0]         rr, grant;
  logic [3:0]         retry_cnt;
  logic [TW-1:0]      timer;
  logic               nack;
  logic [NUM_REQ-1:0] ready_r;
  logic [23:0]        data_r;
  logic               go_r, busy_r;
  logic               done_valid_r, done_nack_r, done_timeout_r;
  logic [1:0]         done_id_r;

  logic [NUM_REQ-1:0] rotated;
  logic [2:0]         search_base, offset, grant_sum;
  logic               grant_found;
  logic [1:0]         grant_idx;
  logic               timer_exp;
  logic               do_accept, do_issue, do_latch, do_retry, do_abort, do_finish, finish_nack;

  // END and ACK come from the controller's slow clock domain
  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      end_meta <= 1'b0;
      end_s    <= 1'b0;
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      end_meta <= bus.i2c_end;
      end_s    <= end_meta;
      ack_meta <= bus.i2c_ack;
      ack_s    <= ack_meta;
    end
  end

  // Rotate the request vector so the search starts just after the last grant
  always_comb begin
    search_base = {1'b0, rr} + 3'd1;
    rotated     = NUM_REQ'({bus.req_valid, bus.req_valid} >> search_base);
    grant_found = 1'b0;
    offset      = 3'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        grant_found = 1'b1;
        offset      = 3'(k);
      end
    end
    grant_sum = search_base + offset;
    grant_idx = (grant_sum >= 3'(NUM_REQ)) ? 2'(grant_sum - 3'(NUM_REQ)) : 2'(grant_sum);
  end

  assign timer_exp = (timer == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n     = state;
    do_accept   = 1'b0;
    do_issue    = 1'b0;
    do_latch    = 1'b0;
    do_retry    = 1'b0;
    do_abort    = 1'b0;
    do_finish   = 1'b0;
    finish_nack = 1'b0;
    case (state)
      IDLE: if (|bus.req_valid) state_n = ARB;
      ARB: begin
        if (grant_found) begin
          do_accept = 1'b1;
          state_n   = ISSUE;
        end else begin
          state_n = IDLE;
        end
      end
      // A stale END still high must not retrigger the controller
      ISSUE: begin
        if (!end_s) begin
          do_issue = 1'b1;
          state_n  = WAIT_END;
        end else if (timer_exp) begin
          do_abort = 1'b1;
          state_n  = DONE;
        end
      end
      WAIT_END: begin
        if (end_s) begin
          do_latch = 1'b1;
          state_n  = WAIT_REL;
        end else if (timer_exp) begin
          do_abort = 1'b1;
          state_n  = DONE;
        end
      end
      WAIT_REL: begin
        if (!end_s) begin
          state_n = CHECK;
        end else if (timer_exp) begin
          do_abort = 1'b1;
          state_n  = DONE;
        end
      end
      CHECK: begin
        if (!nack) begin
          do_finish = 1'b1;
          state_n   = DONE;
        end else if (retry_cnt < 4'(MAX_RETRY)) begin
          do_retry = 1'b1;
          state_n  = ISSUE;
        end else begin
          do_finish   = 1'b1;
          finish_nack = 1'b1;
          state_n     = DONE;
        end
      end
      DONE:    state_n = (|bus.req_valid) ? ARB : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Phase timer restarts on every state change and saturates rather than wraps
  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      rr             <= 2'(NUM_REQ - 1);
      grant          <= 2'd0;
      retry_cnt      <= 4'd0;
      timer          <= '0;
      nack           <= 1'b0;
      ready_r        <= '0;
      data_r         <= 24'd0;
      go_r           <= 1'b0;
      busy_r         <= 1'b0;
      done_valid_r   <= 1'b0;
      done_id_r      <= 2'd0;
      done_nack_r    <= 1'b0;
      done_timeout_r <= 1'b0;
    end else begin
      ready_r        <= '0;
      done_valid_r   <= 1'b0;
      done_nack_r    <= 1'b0;
      done_timeout_r <= 1'b0;
      if (state_n != state)  timer <= '0;
      else if (timer != '1) timer <= timer + TW'(1);
      if (do_accept) begin
        ready_r   <= NUM_REQ'(1) << grant_idx;
        data_r    <= bus.req_data[24*32'(grant_idx) +: 24];
        grant     <= grant_idx;
        rr        <= grant_idx;
        retry_cnt <= 4'd0;
        busy_r    <= 1'b1;
      end
      if (do_issue) go_r <= 1'b1;
      if (do_latch) begin
        go_r <= 1'b0;
        nack <= ack_s;
      end
      if (do_retry) retry_cnt <= retry_cnt + 4'd1;
      if (do_abort || do_finish) begin
        go_r           <= 1'b0;
        done_valid_r   <= 1'b1;
        done_id_r      <= grant;
        done_nack_r    <= finish_nack;
        done_timeout_r <= do_abort;
      end
      if (state == DONE) busy_r <= 1'b0;
    end
  end

  assign bus.req_ready    = ready_r;
  assign bus.i2c_data     = data_r;
  assign bus.i2c_go       = go_r;
  assign bus.busy         = busy_r;
  assign bus.done_valid   = done_valid_r;
  assign bus.done_id      = done_id_r;
  assign bus.done_nack    = done_nack_r;
  assign bus.done_timeout = done_timeout_r;
endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter with a behavioural I2C_Controller that
// answers GO with END, optionally NACKing the first few attempts of a command.
module tb_i2c_cmd_arbiter;
  localparam int NUM_REQ     = 2;
  localparam int MAX_RETRY   = 3;
  localparam int TIMEOUT_CYC = 100;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  int   go_count      = 0;
  int   go_base       = 0;
  int   nack_first    = 0;
  logic model_respond = 1'b1;
  logic model_end     = 1'b0;
  logic model_ack     = 1'b0;
  logic force_end     = 1'b0;

  i2c_cmd_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  assign bus.i2c_end = model_end | force_end;
  assign bus.i2c_ack = model_ack;

  i2c_cmd_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .MAX_RETRY  (MAX_RETRY),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .CLOCK_50(clock),
    .iRST_N  (rst_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  // Controller model: NACKs the first nack_first GO pulses counted from go_base
  always begin
    @(posedge bus.i2c_go);
    go_count = go_count + 1;
    if (model_respond) begin
      repeat (3) @(posedge clock);
      #2;
      model_ack = ((go_count - go_base) <= nack_first);
      model_end = 1'b1;
      for (int i = 0; i < 50 && bus.i2c_go; i++) @(posedge clock);
      #2;
      model_end = 1'b0;
      model_ack = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    bus.req_valid = '0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (bus.done_valid === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_ready(input int budget, output logic [1:0] got);
    got = 2'b00;
    for (int i = 0; i < budget && got == 2'b00; i++) begin
      tick();
      got = bus.req_ready;
    end
    bus.req_valid = '0;
  endtask

  task automatic test_reset();
    bus.req_valid = '0;
    bus.req_data  = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (bus.i2c_go !== 1'b0) begin errors++; $display("[TB] FAIL reset_go: got %b expected 0", bus.i2c_go); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 00", bus.req_ready); end
    checks++; if (bus.done_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done_valid); end
    checks++; if (bus.i2c_data !== 24'h000000) begin errors++; $display("[TB] FAIL reset_data: got %h expected 000000", bus.i2c_data); end
    rst_n = 1'b1;
    repeat (2) tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle: busy got %b expected 0", bus.busy); end
  endtask

  task automatic test_single();
    bit seen;
    int base;
    base       = go_count;
    go_base    = go_count;
    nack_first = 0;
    bus.req_data  = {24'h000000, 24'h340E4D};
    bus.req_valid = 2'b01;
    tick();
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL single_ready_early: got %b expected 00", bus.req_ready); end
    tick();
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL single_ready: got %b expected 01", bus.req_ready); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b expected 1", bus.busy); end
    bus.req_valid = 2'b00;
    tick();
    checks++; if (bus.i2c_go !== 1'b1) begin errors++; $display("[TB] FAIL single_go: got %b expected 1", bus.i2c_go); end
    checks++; if (bus.i2c_data !== 24'h340E4D) begin errors++; $display("[TB] FAIL single_data: got %h expected 340e4d", bus.i2c_data); end
    wait_done(300, seen);
    checks++; if (!seen) begin errors++; $display("[TB] FAIL single_done: done_valid got 0 expected 1 within 300 cycles"); end
    checks++; if (bus.done_id !== 2'd0) begin errors++; $display("[TB] FAIL single_id: got %0d expected 0", bus.done_id); end
    checks++; if (bus.done_nack !== 1'b0 || bus.done_timeout !== 1'b0) begin errors++; $display("[TB] FAIL single_flags: nack %b timeout %b expected 0 0", bus.done_nack, bus.done_timeout); end
    checks++; if (bus.busy !== 1'b1 || bus.i2c_go !== 1'b0) begin errors++; $display("[TB] FAIL single_done_state: busy %b go %b expected 1 0", bus.busy, bus.i2c_go); end
    checks++; if (go_count - base != 1) begin errors++; $display("[TB] FAIL single_go_pulses: got %0d expected 1", go_count - base); end
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.done_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_release: busy %b done %b expected 0 0", bus.busy, bus.done_valid); end
  endtask

  // Both requesters held valid: grants alternate and each follows DONE by two cycles
  task automatic test_round_robin();
    bit         seen;
    int         grants, cyc, last_done, exp_id, double_pulse;
    logic [1:0] exp_ready, prev_ready;
    logic [23:0] exp_data;
    reset_dut();
    go_base      = go_count;
    nack_first   = 0;
    grants       = 0;
    cyc          = 0;
    last_done    = -1;
    double_pulse = 0;
    prev_ready   = 2'b00;
    bus.req_data  = {24'hB20002, 24'hA10001};
    bus.req_valid = 2'b11;
    while (grants < 6 && cyc < 3000) begin
      tick();
      cyc++;
      if (bus.done_valid === 1'b1) last_done = cyc;
      if (bus.req_ready != 2'b00 && prev_ready != 2'b00) double_pulse++;
      prev_ready = bus.req_ready;
      if (bus.req_ready != 2'b00) begin
        exp_id    = grants % 2;
        exp_ready = (exp_id == 0) ? 2'b01 : 2'b10;
        exp_data  = (exp_id == 0) ? 24'hA10001 : 24'hB20002;
        checks++; if (bus.req_ready !== exp_ready) begin errors++; $display("[TB] FAIL rr_grant%0d: ready got %b expected %b", grants, bus.req_ready, exp_ready); end
        checks++; if (bus.i2c_data !== exp_data) begin errors++; $display("[TB] FAIL rr_data%0d: got %h expected %h", grants, bus.i2c_data, exp_data); end
        if (last_done >= 0) begin
          checks++; if (cyc - last_done != 2) begin errors++; $display("[TB] FAIL rr_back_to_back%0d: gap got %0d expected 2", grants, cyc - last_done); end
        end
        grants++;
        if (grants == 6) bus.req_valid = 2'b00;
      end
    end
    checks++; if (grants != 6) begin errors++; $display("[TB] FAIL rr_count: grants got %0d expected 6", grants); end
    wait_done(300, seen);
    if (bus.req_ready != 2'b00) double_pulse++;
    checks++; if (double_pulse != 0) begin errors++; $display("[TB] FAIL rr_ready_width: multi-cycle pulses got %0d expected 0", double_pulse); end
    checks++; if (!seen || bus.done_id !== 2'd1) begin errors++; $display("[TB] FAIL rr_last_done: seen %0d id %0d expected 1 1", seen, bus.done_id); end
    tick();
  endtask

  task automatic test_retry();
    bit         seen;
    int         base;
    logic [1:0] got;
    base       = go_count;
    go_base    = go_count;
    nack_first = 2;
    bus.req_data  = {24'h1A0203, 24'h000000};
    bus.req_valid = 2'b10;
    wait_ready(20, got);
    checks++; if (got !== 2'b10) begin errors++; $display("[TB] FAIL retry_ready: got %b expected 10", got); end
    wait_done(500, seen);
    checks++; if (!seen) begin errors++; $display("[TB] FAIL retry_done: done_valid got 0 expected 1 within 500 cycles"); end
    checks++; if (go_count - base != 3) begin errors++; $display("[TB] FAIL retry_go_pulses: got %0d expected 3", go_count - base); end
    checks++; if (bus.done_nack !== 1'b0 || bus.done_timeout !== 1'b0 || bus.done_id !== 2'd1) begin errors++; $display("[TB] FAIL retry_flags: nack %b timeout %b id %0d expected 0 0 1", bus.done_nack, bus.done_timeout, bus.done_id); end
    tick();

    base       = go_count;
    go_base    = go_count;
    nack_first = 100;
    bus.req_data  = {24'h000000, 24'h1B0405};
    bus.req_valid = 2'b01;
    wait_ready(20, got);
    wait_done(600, seen);
    checks++; if (!seen) begin errors++; $display("[TB] FAIL nack_done: done_valid got 0 expected 1 within 600 cycles"); end
    checks++; if (go_count - base != 4) begin errors++; $display("[TB] FAIL nack_go_pulses: got %0d expected 4", go_count - base); end
    checks++; if (bus.done_nack !== 1'b1 || bus.done_timeout !== 1'b0 || bus.done_id !== 2'd0) begin errors++; $display("[TB] FAIL nack_flags: nack %b timeout %b id %0d expected 1 0 0", bus.done_nack, bus.done_timeout, bus.done_id); end
    nack_first = 0;
    tick();
  endtask

  task automatic test_timeout();
    int         high, n;
    logic [1:0] got;
    model_respond = 1'b0;
    bus.req_data  = {24'h000000, 24'h5A5A5A};
    bus.req_valid = 2'b01;
    wait_ready(20, got);
    n = 0;
    while (bus.i2c_go !== 1'b1 && n < 10) begin tick(); n++; end
    checks++; if (bus.i2c_go !== 1'b1) begin errors++; $display("[TB] FAIL timeout_go_rise: got %b expected 1", bus.i2c_go); end
    high = 0;
    while (bus.i2c_go === 1'b1 && high < 300) begin tick(); high++; end
    checks++; if (high != 100) begin errors++; $display("[TB] FAIL timeout_go_cycles: got %0d expected 100", high); end
    checks++; if (bus.done_valid !== 1'b1 || bus.done_timeout !== 1'b1 || bus.done_nack !== 1'b0) begin errors++; $display("[TB] FAIL timeout_flags: done %b timeout %b nack %b expected 1 1 0", bus.done_valid, bus.done_timeout, bus.done_nack); end
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.done_valid !== 1'b0) begin errors++; $display("[TB] FAIL timeout_release: busy %b done %b expected 0 0", bus.busy, bus.done_valid); end
    model_respond = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit         seen;
    int         n;
    logic [1:0] got;
    go_base    = go_count;
    nack_first = 0;
    bus.req_data  = {24'h000000, 24'h112233};
    bus.req_valid = 2'b01;
    wait_ready(20, got);
    n = 0;
    while (bus.i2c_go !== 1'b1 && n < 10) begin tick(); n++; end
    checks++; if (bus.i2c_go !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_go_rise: got %b expected 1", bus.i2c_go); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.i2c_go !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL rstmid_async: go %b busy %b ready %b expected 0 0 00", bus.i2c_go, bus.busy, bus.req_ready); end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    checks++; if (bus.i2c_go !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_forgotten: go %b busy %b expected 0 0", bus.i2c_go, bus.busy); end
    go_base = go_count;
    bus.req_data  = {24'h224466, 24'h000000};
    bus.req_valid = 2'b10;
    tick();
    tick();
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("[TB] FAIL rstmid_req1_ready: got %b expected 10", bus.req_ready); end
    bus.req_valid = 2'b00;
    wait_done(300, seen);
    checks++; if (!seen || bus.done_id !== 2'd1 || bus.done_nack !== 1'b0 || bus.done_timeout !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_req1_done: seen %0d id %0d nack %b timeout %b expected 1 1 0 0", seen, bus.done_id, bus.done_nack, bus.done_timeout); end
    tick();
  endtask

  // END already high at acceptance: GO waits three cycles after END falls
  task automatic test_end_stuck();
    bit         seen;
    int         base, early_go, n;
    logic [1:0] got;
    force_end = 1'b1;
    repeat (5) tick();
    base       = go_count;
    go_base    = go_count;
    nack_first = 0;
    bus.req_data  = {24'h000000, 24'h770102};
    bus.req_valid = 2'b01;
    wait_ready(20, got);
    checks++; if (got !== 2'b01) begin errors++; $display("[TB] FAIL stuck_ready: got %b expected 01", got); end
    early_go = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.i2c_go === 1'b1) early_go++;
    end
    checks++; if (early_go != 0) begin errors++; $display("[TB] FAIL stuck_no_go: go high cycles got %0d expected 0", early_go); end
    force_end = 1'b0;
    n = 0;
    while (bus.i2c_go !== 1'b1 && n < 10) begin tick(); n++; end
    checks++; if (n != 3) begin errors++; $display("[TB] FAIL stuck_go_delay: got %0d expected 3", n); end
    wait_done(300, seen);
    checks++; if (!seen || bus.done_nack !== 1'b0 || bus.done_timeout !== 1'b0) begin errors++; $display("[TB] FAIL stuck_done: seen %0d nack %b timeout %b expected 1 0 0", seen, bus.done_nack, bus.done_timeout); end
    checks++; if (go_count - base != 1) begin errors++; $display("[TB] FAIL stuck_go_pulses: got %0d expected 1", go_count - base); end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_retry();
    test_timeout();
    test_reset_mid();
    test_end_stuck();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
